// File: rtl/instruction_cache.sv
// instruction_cache: direct-mapped read-only I-cache, byte-serial line fill.
// Define ICACHE_PERF_CNT_EN to add perf_hit_cnt / perf_miss_cnt outputs.
module instruction_cache #(
    parameter int LINE_BYTES = 16,
    parameter int LINES      = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        icache_fetch_en,
    input  logic [16:0] icache_fetch_addr,
    input  logic        icache_flush,
    output logic        icache_out_en,
    output logic [31:0] icache_instruction,
    output logic        icache_cinstruction,
`ifdef ICACHE_PERF_CNT_EN
    output logic [31:0] perf_hit_cnt,
    output logic [31:0] perf_miss_cnt,
`endif
    output logic        mem_req_en,
    output logic [16:0] mem_req_addr,
    input  logic        mem_rdy,
    input  logic [7:0]  mem_byte
);
    localparam int OB = $clog2(LINE_BYTES);
    localparam int IB = $clog2(LINES);
    localparam int TB = 17 - OB - IB;
    localparam logic [OB-1:0] LAST_OFF = OB'(LINE_BYTES - 1);
    localparam logic [OB-1:0] SPAN_OFF = OB'(LINE_BYTES - 2);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [16:0]       addr_q, addr_d;
    logic              sec_q, sec_d;
    logic [OB-1:0]     cnt_q, cnt_d;
    logic              flush_pend_q, flush_pend_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic              out_en_q, out_en_d;
    logic [31:0]       instr_q, instr_d;
    logic              cinstr_q, cinstr_d;
    logic              req_q, req_d;
    logic [16:0]       req_addr_q, req_addr_d;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]       hit_cnt_q, hit_cnt_d;
    logic [31:0]       miss_cnt_q, miss_cnt_d;
`endif

    logic [7:0]        data_q [LINES][LINE_BYTES];
    logic [TB-1:0]     tag_q  [LINES];

    logic [16:0]       cur_addr, l0_base, l1_base;
    logic [16:0]       ba [4];
    logic [7:0]        rd_byte [4];
    logic [15:0]       hw;
    logic              comp, span, hit0, hit1;
    logic [31:0]       word;
    logic              wr_en, wr_last;
    logic [IB-1:0]     wr_idx;
    logic [OB-1:0]     wr_off;

    // Fill write port; the byte arriving this cycle is bypassed to readers.
    always_comb begin
        wr_en   = (state_q == S_FILL) && req_q && mem_rdy;
        wr_idx  = req_addr_q[OB+IB-1:OB];
        wr_off  = cnt_q;
        wr_last = wr_en && (cnt_q == LAST_OFF);
    end

    // Assemble the word at the fetch address and evaluate line hits.
    always_comb begin
        cur_addr = (state_q == S_IDLE) ? icache_fetch_addr : addr_q;
        l0_base  = {cur_addr[16:OB], {OB{1'b0}}};
        l1_base  = l0_base + 17'(LINE_BYTES);
        for (int k = 0; k < 4; k++) begin
            ba[k]      = cur_addr + 17'(k);
            rd_byte[k] = data_q[ba[k][OB+IB-1:OB]][ba[k][OB-1:0]];
            if (wr_en && ba[k][OB+IB-1:OB] == wr_idx
                && ba[k][OB-1:0] == wr_off) begin
                rd_byte[k] = mem_byte;
            end
        end
        hw   = {rd_byte[1], rd_byte[0]};
        comp = (hw[1:0] != 2'b11);
        span = (cur_addr[OB-1:0] == SPAN_OFF) && !comp;
        word = comp ? {16'h0000, hw}
                    : {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};
        hit0 = valid_q[l0_base[OB+IB-1:OB]]
            && (tag_q[l0_base[OB+IB-1:OB]] == l0_base[16:OB+IB]);
        hit1 = valid_q[l1_base[OB+IB-1:OB]]
            && (tag_q[l1_base[OB+IB-1:OB]] == l1_base[16:OB+IB]);
    end

    // Next-state logic: lookup, line fills, delivery, deferred flush.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        sec_d        = sec_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q;
        valid_d      = valid_q;
        out_en_d     = 1'b0;
        instr_d      = instr_q;
        cinstr_d     = cinstr_q;
        req_d        = req_q;
        req_addr_d   = req_addr_q;
`ifdef ICACHE_PERF_CNT_EN
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (icache_flush) valid_d = '0;
                if (icache_fetch_en) begin
                    addr_d = icache_fetch_addr;
                    cnt_d  = '0;
                    if (icache_flush || !hit0) begin
                        state_d    = S_FILL;
                        sec_d      = 1'b0;
                        req_d      = 1'b1;
                        req_addr_d = l0_base;
`ifdef ICACHE_PERF_CNT_EN
                        miss_cnt_d = miss_cnt_q + 32'd1;
`endif
                    end else if (span && !hit1) begin
                        state_d    = S_FILL;
                        sec_d      = 1'b1;
                        req_d      = 1'b1;
                        req_addr_d = l1_base;
`ifdef ICACHE_PERF_CNT_EN
                        miss_cnt_d = miss_cnt_q + 32'd1;
`endif
                    end else begin
                        state_d  = S_DONE;
                        out_en_d = 1'b1;
                        instr_d  = word;
                        cinstr_d = comp;
`ifdef ICACHE_PERF_CNT_EN
                        hit_cnt_d = hit_cnt_q + 32'd1;
`endif
                    end
                end
            end
            S_FILL: begin
                if (icache_flush) flush_pend_d = 1'b1;
                if (!req_q) req_d = 1'b1;
                if (wr_en) cnt_d = cnt_q + 1'b1;
                if (wr_last) begin
                    valid_d[wr_idx] = 1'b1;
                    req_d           = 1'b0;
                    if (!sec_q && span && !hit1) begin
                        sec_d      = 1'b1;
                        req_addr_d = l1_base;
                    end else begin
                        state_d  = S_DONE;
                        out_en_d = 1'b1;
                        instr_d  = word;
                        cinstr_d = comp;
                    end
                end
            end
            S_DONE: begin
                state_d      = S_IDLE;
                flush_pend_d = 1'b0;
                if (flush_pend_q || icache_flush) valid_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            sec_q        <= 1'b0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
            out_en_q     <= 1'b0;
            instr_q      <= '0;
            cinstr_q     <= 1'b0;
            req_q        <= 1'b0;
            req_addr_q   <= '0;
`ifdef ICACHE_PERF_CNT_EN
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            sec_q        <= sec_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            valid_q      <= valid_d;
            out_en_q     <= out_en_d;
            instr_q      <= instr_d;
            cinstr_q     <= cinstr_d;
            req_q        <= req_d;
            req_addr_q   <= req_addr_d;
`ifdef ICACHE_PERF_CNT_EN
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
`endif
        end
    end

    // Line data and tag storage; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (wr_en) data_q[wr_idx][wr_off] <= mem_byte;
        if (wr_last) tag_q[wr_idx] <= req_addr_q[16:OB+IB];
    end

    assign icache_out_en       = out_en_q;
    assign icache_instruction  = instr_q;
    assign icache_cinstruction = cinstr_q;
    assign mem_req_en          = req_q;
    assign mem_req_addr        = req_addr_q;
`ifdef ICACHE_PERF_CNT_EN
    assign perf_hit_cnt        = hit_cnt_q;
    assign perf_miss_cnt       = miss_cnt_q;
`endif
endmodule
